// File: rtl/chan_est_eq_param_pkg.sv
// Shared types and constants for the pilot-based channel estimator / equalizer.
package chan_est_eq_param_pkg;

  localparam int unsigned DefNSc    = 28;
  localparam int unsigned DefNPilot = 4;
  localparam int unsigned DefNSym   = 8;
  localparam int unsigned DefW      = 8;
  localparam int unsigned DefFrac   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoadPilot,
    StEstimate,
    StEqualize,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    PhRead,
    PhStart,
    PhWait
  } eq_phase_e;

  function automatic int sat_max(int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/chan_est_eq_param_seq_divider.sv
// Unsigned restoring divider: NW iterations, one quotient bit per cycle, sync abort.
module seq_divider #(
  parameter int unsigned NW = 12,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          abort,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [NW-1:0] quotient,
  output logic          done
);
  localparam int unsigned CntW = $clog2(NW + 1);

  logic [DW-1:0]   rem_q;
  logic [DW-1:0]   div_q;
  logic [NW-1:0]   quo_q;
  logic [CntW-1:0] cnt_q;
  logic            run_q;
  logic [DW:0]     shifted;
  logic [DW:0]     diff;

  assign shifted  = {rem_q, quo_q[NW-1]};
  // Partial remainder stays below 2*divisor, so diff's MSB is the borrow.
  assign diff     = shifted - {1'b0, div_q};
  assign quotient = quo_q;

  always_ff @(posedge clk) begin
    if (abort) begin
      run_q <= 1'b0;
      done  <= 1'b0;
      cnt_q <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= '0;
        quo_q <= dividend;
        div_q <= divisor;
        cnt_q <= CntW'(NW);
        run_q <= 1'b1;
      end else if (run_q) begin
        if (!diff[DW]) begin
          rem_q <= diff[DW-1:0];
          quo_q <= {quo_q[NW-2:0], 1'b1};
        end else begin
          rem_q <= shifted[DW-1:0];
          quo_q <= {quo_q[NW-2:0], 1'b0};
        end
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/chan_est_eq_param.sv
// Pilot-averaged per-subcarrier channel estimate and zero-forcing equalizer.
module chan_est_eq_param
  import chan_est_eq_param_pkg::*;
#(
  parameter int unsigned N_SC    = DefNSc,
  parameter int unsigned N_PILOT = DefNPilot,
  parameter int unsigned N_SYM   = DefNSym,
  parameter int unsigned W       = DefW,
  parameter int unsigned FRAC    = DefFrac
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2*W-1:0]                  din,
  input  logic                            din_valid,
  input  logic                            tx_done,
  input  logic [$clog2(N_SC*N_SYM)-1:0]   rd_addr,
  output logic [2*W-1:0]                  dout,
  output logic                            out_buff_full,
  output logic                            busy,
  output logic                            ovf
);
  localparam int unsigned NData = N_SC * N_SYM;
  localparam int unsigned NPil  = N_SC * N_PILOT;
  localparam int unsigned NTot  = NPil + NData;
  localparam int unsigned Lp    = $clog2(N_PILOT);
  localparam int unsigned Aw    = $clog2(NData);
  localparam int unsigned Cw    = $clog2(NTot + 1);
  localparam int unsigned Dcw   = $clog2(NData + 1);
  localparam int unsigned Scw   = $clog2(N_SC);
  localparam int unsigned AccW  = W + Lp;
  localparam int unsigned Nw    = W + FRAC;
  localparam logic signed [W-1:0] SatMax = W'(sat_max(W));
  localparam logic signed [W-1:0] SatMin = W'(sat_min(W));
  localparam logic [Nw-1:0] QPos = Nw'(sat_max(W));
  localparam logic [Nw-1:0] QNeg = Nw'(-sat_min(W));

  logic signed [AccW-1:0] acc_ram   [N_SC];
  logic [W-1:0]           coeff_ram [N_SC];
  logic [2*W-1:0]         data_ram  [NData];
  logic [2*W-1:0]         out_ram   [NData];

  state_e                 state_q;
  eq_phase_e              phase_q;
  logic [Cw-1:0]          in_cnt_q;
  logic [Scw-1:0]         sc_q;
  logic [Dcw-1:0]         data_cnt_q;
  logic [Scw-1:0]         est_q;
  logic [Aw-1:0]          eq_i_q;
  logic [Scw-1:0]         eq_sc_q;
  logic signed [W-1:0]    x_re_q, x_im_q;
  logic [W-1:0]           c_q;

  logic clr, in_pilot, in_data, pil_we, data_we, est_we, div_start, div_done, out_we;
  logic done_re, done_im;
  logic signed [W-1:0]    din_re;
  logic signed [AccW-1:0] acc_next, est_avg;
  logic [W-1:0]           est_coeff;
  logic [Nw-1:0]          q_re, q_im;
  logic [2*W-1:0]         out_wdata;

  function automatic logic [Nw-1:0] mag(logic signed [W-1:0] x);
    logic [W-1:0] a;
    a = x[W-1] ? W'(-x) : W'(x);
    return Nw'(a) << FRAC;
  endfunction

  function automatic logic [W-1:0] zero_div(logic signed [W-1:0] x);
    return x[W-1] ? SatMin : ((x == '0) ? '0 : SatMax);
  endfunction

  function automatic logic [W-1:0] apply_sign(logic neg, logic [Nw-1:0] q);
    if (neg) return (q > QNeg) ? SatMin : W'(-q);
    return (q > QPos) ? SatMax : W'(q);
  endfunction

  assign clr      = rst | tx_done;
  assign in_pilot = in_cnt_q < Cw'(NPil);
  assign in_data  = !in_pilot && (in_cnt_q < Cw'(NTot));
  assign pil_we   = din_valid && !clr && in_pilot;
  assign data_we  = din_valid && !clr && in_data;
  assign est_we   = (state_q == StEstimate) && !clr;
  assign din_re   = din[W-1:0];
  // First pilot symbol overwrites whatever a previous burst left behind.
  assign acc_next = (in_cnt_q < Cw'(N_SC)) ? AccW'(din_re) : acc_ram[sc_q] + AccW'(din_re);
  assign est_avg  = acc_ram[est_q] >>> Lp;
  assign est_coeff = est_avg[AccW-1] ? W'(-est_avg) : W'(est_avg);
  assign div_start = (state_q == StEqualize) && (phase_q == PhStart) && (c_q != '0) && !clr;
  assign div_done  = done_re & done_im;

  always_comb begin
    out_we    = 1'b0;
    out_wdata = '0;
    if ((state_q == StEqualize) && !clr) begin
      if ((phase_q == PhStart) && (c_q == '0)) begin
        out_we    = 1'b1;
        out_wdata = {zero_div(x_im_q), zero_div(x_re_q)};
      end else if ((phase_q == PhWait) && div_done) begin
        out_we    = 1'b1;
        out_wdata = {apply_sign(x_im_q[W-1], q_im), apply_sign(x_re_q[W-1], q_re)};
      end
    end
  end

  seq_divider #(.NW(Nw), .DW(W)) u_div_re (
    .clk     (clk),
    .abort   (clr),
    .start   (div_start),
    .dividend(mag(x_re_q)),
    .divisor (c_q),
    .quotient(q_re),
    .done    (done_re)
  );

  seq_divider #(.NW(Nw), .DW(W)) u_div_im (
    .clk     (clk),
    .abort   (clr),
    .start   (div_start),
    .dividend(mag(x_im_q)),
    .divisor (c_q),
    .quotient(q_im),
    .done    (done_im)
  );

  always_ff @(posedge clk) if (pil_we)  acc_ram[sc_q] <= acc_next;
  always_ff @(posedge clk) if (est_we)  coeff_ram[est_q] <= est_coeff;
  always_ff @(posedge clk) if (data_we) data_ram[data_cnt_q[Aw-1:0]] <= din;
  always_ff @(posedge clk) if (out_we)  out_ram[eq_i_q] <= out_wdata;

  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= out_ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= StIdle;
      phase_q       <= PhRead;
      in_cnt_q      <= '0;
      sc_q          <= '0;
      data_cnt_q    <= '0;
      est_q         <= '0;
      eq_i_q        <= '0;
      eq_sc_q       <= '0;
      ovf           <= 1'b0;
      out_buff_full <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (din_valid) begin
        if (in_cnt_q == Cw'(NTot)) begin
          ovf <= 1'b1;
        end else begin
          in_cnt_q <= in_cnt_q + 1'b1;
          sc_q     <= (sc_q == Scw'(N_SC - 1)) ? '0 : sc_q + 1'b1;
          if (in_data) data_cnt_q <= data_cnt_q + 1'b1;
        end
      end
      unique case (state_q)
        StIdle: if (din_valid) begin
          state_q <= StLoadPilot;
          busy    <= 1'b1;
        end
        StLoadPilot: if (!in_pilot) state_q <= StEstimate;
        StEstimate: begin
          est_q <= (est_q == Scw'(N_SC - 1)) ? '0 : est_q + 1'b1;
          if (est_q == Scw'(N_SC - 1)) state_q <= StEqualize;
        end
        StEqualize: begin
          // Stall on underrun: only issue samples already stored.
          if ((phase_q == PhRead) && (Dcw'(eq_i_q) < data_cnt_q)) begin
            x_re_q  <= data_ram[eq_i_q][W-1:0];
            x_im_q  <= data_ram[eq_i_q][2*W-1:W];
            c_q     <= coeff_ram[eq_sc_q];
            phase_q <= PhStart;
          end else if ((phase_q == PhStart) && (c_q != '0)) begin
            phase_q <= PhWait;
          end
          if (out_we) begin
            phase_q <= PhRead;
            eq_sc_q <= (eq_sc_q == Scw'(N_SC - 1)) ? '0 : eq_sc_q + 1'b1;
            if (eq_i_q == Aw'(NData - 1)) begin
              state_q       <= StDone;
              out_buff_full <= 1'b1;
              busy          <= 1'b0;
            end else begin
              eq_i_q <= eq_i_q + 1'b1;
            end
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
